// File: rtl/mem_nibble_bridge_if.sv
// rtl/mem_nibble_bridge_if.sv - request/response and nibble-pad bundle for mem_nibble_bridge
//
// Purpose: groups the core-side request/response channels and the pad-side
// nibble channels of the bridge.
//   master : core side plus external device (drives req_*, rsp_ready, nib_in*)
//   slave  : the bridge (drives req_ready, rsp_*, nib_out*)
// Signals:
//   req_addr[31:0], req_wdata[31:0], req_strb[3:0], req_write, req_valid, req_ready
//   rsp_rdata[31:0], rsp_error, rsp_valid, rsp_ready
//   nib_out[3:0], nib_out_valid (also pad output enable), nib_in[3:0], nib_in_valid

interface mem_nibble_bridge_if;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        req_write;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  nib_out;
    logic        nib_out_valid;
    logic [3:0]  nib_in;
    logic        nib_in_valid;

    modport master (
        output req_addr, req_wdata, req_strb, req_write, req_valid, rsp_ready,
        output nib_in, nib_in_valid,
        input  req_ready, rsp_rdata, rsp_error, rsp_valid, nib_out, nib_out_valid
    );

    modport slave (
        input  req_addr, req_wdata, req_strb, req_write, req_valid, rsp_ready,
        input  nib_in, nib_in_valid,
        output req_ready, rsp_rdata, rsp_error, rsp_valid, nib_out, nib_out_valid
    );
endinterface

// File: rtl/mem_nibble_bridge.sv
// rtl/mem_nibble_bridge.sv - 32-bit memory request to 4-bit nibble stream bridge
//
// Purpose: serialises one data-memory request at a time into a nibble frame
// (header, strobes, address, optional write data) and reassembles the
// device's nibble response into a 32-bit response with error flag.
// Parameters:
//   ADDR_NIBBLES : address nibbles per frame (1..8), LSB nibble first
//   TIMEOUT      : silent response-wait cycles before an error response (0 = off)
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mem_nibble_bridge_if.slave (request, response and nibble channels)
// All outputs are decoded from registered state only.

module mem_nibble_bridge #(
    parameter int ADDR_NIBBLES = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_nibble_bridge_if.slave    bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR0  = 3'd1;
    localparam logic [2:0] S_HDR1  = 3'd2;
    localparam logic [2:0] S_ADDR  = 3'd3;
    localparam logic [2:0] S_WDATA = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_RESP  = 3'd6;

    // The timeout counter only ever holds 0..TIMEOUT-1: reaching TIMEOUT is
    // detected on the increment and turns straight into the error response.
    localparam int         CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [3:0] ADDR_LAST = 4'(ADDR_NIBBLES - 1);

    logic [2:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    strb_q, strb_d;
    logic          write_q, write_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    strb_d  = bus.req_write ? bus.req_strb : 4'hF;
                    write_d = bus.req_write;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = S_HDR0;
                end
            end
            S_HDR0: state_d = S_HDR1;
            S_HDR1: begin
                cnt_d   = 4'd0;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                // The current nibble is always addr_q[3:0]; shift to expose the next.
                addr_d = addr_q >> 4;
                if (cnt_q == ADDR_LAST) begin
                    cnt_d   = 4'd0;
                    tmo_d   = '0;
                    state_d = write_q ? S_WDATA : S_WAIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WDATA: begin
                wdata_d = wdata_q >> 4;
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (bus.nib_in_valid) begin
                    tmo_d = '0;
                    if (write_q) begin
                        rdata_d = 32'h0;
                        err_d   = bus.nib_in[0];
                        state_d = S_RESP;
                    end else begin
                        // Shift in from the top so the k-th nibble ends in [4k+3:4k].
                        rdata_d = {bus.nib_in, rdata_q[31:4]};
                        if (cnt_q == 4'd7) begin
                            err_d   = 1'b0;
                            state_d = S_RESP;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    if (tmo_q == TMO_LAST) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            strb_q  <= 4'h0;
            write_q <= 1'b0;
            cnt_q   <= 4'd0;
            tmo_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    logic [3:0] nib_out_w;
    always_comb begin
        nib_out_w = 4'h0;
        case (state_q)
            S_HDR0:  nib_out_w = {3'b100, write_q};
            S_HDR1:  nib_out_w = strb_q;
            S_ADDR:  nib_out_w = addr_q[3:0];
            S_WDATA: nib_out_w = wdata_q[3:0];
            default: nib_out_w = 4'h0;
        endcase
    end

    assign bus.nib_out       = nib_out_w;
    assign bus.nib_out_valid = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                               (state_q == S_ADDR) || (state_q == S_WDATA);
    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.rsp_valid     = (state_q == S_RESP);
    // Gate with RESP so partial read data never shows outside a response.
    assign bus.rsp_rdata     = (state_q == S_RESP) ? rdata_q : 32'h0;
    assign bus.rsp_error     = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_mem_nibble_bridge.sv
// tb/tb_mem_nibble_bridge.sv - self-checking bench for mem_nibble_bridge

module tb_mem_nibble_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_strb = 4'h0;
    logic        req_write = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [3:0]  nib_in = 4'h0;
    logic        nib_in_valid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    bit sel = 1'b0;
    logic [3:0] dev_q[$];

    always #5 clk = ~clk;

    mem_nibble_bridge_if if0 ();
    mem_nibble_bridge_if if1 ();

    assign if0.req_addr = req_addr;   assign if1.req_addr = req_addr;
    assign if0.req_wdata = req_wdata; assign if1.req_wdata = req_wdata;
    assign if0.req_strb = req_strb;   assign if1.req_strb = req_strb;
    assign if0.req_write = req_write; assign if1.req_write = req_write;
    assign if0.req_valid = req_valid; assign if1.req_valid = req_valid;
    assign if0.rsp_ready = rsp_ready; assign if1.rsp_ready = rsp_ready;
    assign if0.nib_in = nib_in;       assign if1.nib_in = nib_in;
    assign if0.nib_in_valid = nib_in_valid; assign if1.nib_in_valid = nib_in_valid;

    mem_nibble_bridge #(.ADDR_NIBBLES(8), .TIMEOUT(255)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    mem_nibble_bridge #(.ADDR_NIBBLES(3), .TIMEOUT(4))   dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    wire        o_req_ready     = sel ? if1.req_ready     : if0.req_ready;
    wire [31:0] o_rsp_rdata     = sel ? if1.rsp_rdata     : if0.rsp_rdata;
    wire        o_rsp_error     = sel ? if1.rsp_error     : if0.rsp_error;
    wire        o_rsp_valid     = sel ? if1.rsp_valid     : if0.rsp_valid;
    wire [3:0]  o_nib_out       = sel ? if1.nib_out       : if0.nib_out;
    wire        o_nib_out_valid = sel ? if1.nib_out_valid : if0.nib_out_valid;

    function automatic int an_f();
        return sel ? 3 : 8;
    endfunction

    task automatic do_reset();
        req_valid = 1'b0; nib_in_valid = 1'b0; rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Issue a request and capture the outbound frame; returns at the negedge of
    // the first cycle after the frame (first WAIT cycle).
    task automatic do_frame(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                            input logic wr, input string nm);
        logic [3:0] expq[$];
        logic [3:0] got[$];
        int g;
        expq.push_back({3'b100, wr});
        expq.push_back(wr ? st : 4'hF);
        for (int k = 0; k < an_f(); k++) expq.push_back(a[4*k +: 4]);
        if (wr) for (int k = 0; k < 8; k++) expq.push_back(wd[4*k +: 4]);
        g = 0;
        @(negedge clk);
        while (o_req_ready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        n_cmp++;
        if (o_req_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s req_ready_wait: got %b want 1", nm, o_req_ready);
        end
        req_addr = a; req_wdata = wd; req_strb = st; req_write = wr; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while (o_nib_out_valid === 1'b1 && g < 40) begin
            got.push_back(o_nib_out); g++; @(negedge clk);
        end
        n_cmp++;
        if (got.size() != expq.size()) begin
            n_bad++; $display("FAIL %s frame_len: got %0d want %0d", nm, got.size(), expq.size());
        end else begin
            for (int i = 0; i < got.size(); i++) begin
                n_cmp++;
                if (got[i] !== expq[i]) begin
                    n_bad++; $display("FAIL %s frame_nib%0d: got %h want %h", nm, i, got[i], expq[i]);
                end
            end
        end
        n_cmp++;
        if (o_nib_out !== 4'h0) begin
            n_bad++; $display("FAIL %s idle_nib_out: got %h want 0", nm, o_nib_out);
        end
    endtask

    // Play dev_q back as the device response and check the resulting response.
    task automatic do_response(input logic wr, input bit randgap, input string nm);
        logic [31:0] exp_rd;
        logic        exp_err;
        bit          early;
        exp_rd = 32'h0; early = 1'b0;
        exp_err = wr ? dev_q[0][0] : 1'b0;
        if (!wr) for (int i = 0; i < 8; i++) exp_rd[4*i +: 4] = dev_q[i];
        for (int i = 0; i < dev_q.size(); i++) begin
            if (randgap) begin
                repeat ($urandom_range(0, 3)) begin
                    nib_in_valid = 1'b0; nib_in = 4'($urandom);
                    @(negedge clk);
                    if (o_rsp_valid === 1'b1) early = 1'b1;
                end
            end
            nib_in = dev_q[i]; nib_in_valid = 1'b1;
            @(negedge clk);
            nib_in_valid = 1'b0;
            if (i < dev_q.size() - 1 && o_rsp_valid === 1'b1) early = 1'b1;
        end
        n_cmp++;
        if (early || o_rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL %s rsp_valid_timing: got %b early=%0d want 1", nm, o_rsp_valid, early);
        end
        n_cmp++;
        if (o_rsp_rdata !== exp_rd) begin
            n_bad++; $display("FAIL %s rsp_rdata: got %h want %h", nm, o_rsp_rdata, exp_rd);
        end
        n_cmp++;
        if (o_rsp_error !== exp_err) begin
            n_bad++; $display("FAIL %s rsp_error: got %b want %b", nm, o_rsp_error, exp_err);
        end
    endtask

    task automatic finish_rsp(input string nm);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s handshake: got valid=%b ready=%b want 0/1", nm, o_rsp_valid, o_req_ready);
        end
    endtask

    task automatic fill_rand_read();
        dev_q.delete();
        for (int i = 0; i < 8; i++) dev_q.push_back(4'($urandom));
    endtask

    task automatic test_reset();
        sel = 1'b0;
        n_cmp++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rsp_error !== 1'b0 ||
            o_rsp_rdata !== 32'h0 || o_nib_out !== 4'h0 || o_nib_out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_values: got rdy=%b v=%b e=%b rd=%h n=%h nv=%b want 1/0/0/0/0/0",
                o_req_ready, o_rsp_valid, o_rsp_error, o_rsp_rdata, o_nib_out, o_nib_out_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        req_addr = $urandom; req_wdata = $urandom; req_strb = 4'hA; req_write = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (11) @(negedge clk);
        n_cmp++;
        if (o_nib_out_valid !== 1'b1) begin
            n_bad++; $display("FAIL reset_pre_wdata_valid: got %b want 1", o_nib_out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (o_nib_out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_async_drop: got %b want 0", o_nib_out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_after_release: got rdy=%b v=%b want 1/0", o_req_ready, o_rsp_valid);
        end
        fill_rand_read();
        do_frame($urandom, 32'h0, 4'h0, 1'b0, "reset_read");
        do_response(1'b0, 1'b0, "reset_read");
        finish_rsp("reset_read");
    endtask

    task automatic test_read();
        sel = 1'b0;
        do_reset();
        dev_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        do_frame(32'h1234_5678, 32'h0, 4'h0, 1'b0, "read_vec");
        do_response(1'b0, 1'b0, "read_vec");
        finish_rsp("read_vec");
        for (int t = 0; t < 4; t++) begin
            fill_rand_read();
            do_frame($urandom, $urandom, 4'($urandom), 1'b0, "read_rand");
            do_response(1'b0, 1'b1, "read_rand");
            finish_rsp("read_rand");
        end
    endtask

    task automatic test_write();
        sel = 1'b0;
        do_reset();
        dev_q = '{4'h0};
        do_frame(32'h0000_0010, 32'hCAFE_BABE, 4'b0011, 1'b1, "write_ack0");
        do_response(1'b1, 1'b0, "write_ack0");
        finish_rsp("write_ack0");
        dev_q = '{4'h1};
        do_frame(32'h0000_0010, 32'hCAFE_BABE, 4'b0011, 1'b1, "write_ack1");
        do_response(1'b1, 1'b0, "write_ack1");
        finish_rsp("write_ack1");
        for (int t = 0; t < 4; t++) begin
            dev_q.delete();
            dev_q.push_back(4'($urandom));
            do_frame($urandom, $urandom, 4'($urandom), 1'b1, "write_rand");
            do_response(1'b1, 1'b1, "write_rand");
            finish_rsp("write_rand");
        end
    endtask

    task automatic test_timeout();
        int k;
        sel = 1'b1;
        do_reset();
        do_frame($urandom, 32'h0, 4'h0, 1'b0, "timeout");
        for (int i = 0; i < 3; i++) begin
            nib_in = 4'($urandom); nib_in_valid = 1'b1;
            @(negedge clk);
        end
        nib_in_valid = 1'b0;
        k = 1;
        while (o_rsp_valid !== 1'b1 && k < 20) begin
            nib_in = 4'($urandom);
            @(negedge clk); k++;
        end
        n_cmp++;
        if (k != 5) begin
            n_bad++; $display("FAIL timeout_latency: got %0d want 5", k);
        end
        n_cmp++;
        if (o_rsp_error !== 1'b1 || o_rsp_rdata !== 32'h0) begin
            n_bad++; $display("FAIL timeout_rsp: got e=%b rd=%h want 1/0", o_rsp_error, o_rsp_rdata);
        end
        finish_rsp("timeout");
    endtask

    task automatic test_backpressure();
        logic [31:0] rd0;
        bit bad;
        sel = 1'b0;
        do_reset();
        fill_rand_read();
        do_frame($urandom, 32'h0, 4'h0, 1'b0, "bp");
        do_response(1'b0, 1'b0, "bp");
        rd0 = o_rsp_rdata; bad = 1'b0;
        req_addr = $urandom; req_write = 1'b0; req_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== rd0 || o_req_ready !== 1'b0 ||
                o_nib_out_valid !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++; $display("FAIL bp_hold: got v=%b rd=%h rdy=%b want 1/%h/0", o_rsp_valid, o_rsp_rdata, o_req_ready, rd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_nib_out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_release: got v=%b rdy=%b nv=%b want 0/1/0", o_rsp_valid, o_req_ready, o_nib_out_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (o_nib_out_valid !== 1'b1 || o_nib_out !== 4'h8) begin
            n_bad++; $display("FAIL bp_accept_next: got nv=%b n=%h want 1/8", o_nib_out_valid, o_nib_out);
        end
    endtask

    task automatic test_addr3();
        sel = 1'b1;
        do_reset();
        dev_q = '{4'h9, 4'h0, 4'hF, 4'h3, 4'h5, 4'hA, 4'hC, 4'h6};
        do_frame(32'hFFFF_FABC, 32'h0, 4'h0, 1'b0, "addr3_vec");
        do_response(1'b0, 1'b0, "addr3_vec");
        finish_rsp("addr3_vec");
        for (int t = 0; t < 3; t++) begin
            fill_rand_read();
            do_frame($urandom, 32'h0, 4'h0, 1'b0, "addr3_rand");
            do_response(1'b0, 1'b1, "addr3_rand");
            finish_rsp("addr3_rand");
        end
        dev_q = '{4'h0};
        do_frame($urandom, $urandom, 4'($urandom), 1'b1, "addr3_write");
        do_response(1'b1, 1'b0, "addr3_write");
        finish_rsp("addr3_write");
    endtask

    task automatic test_back_to_back();
        int starts[$];
        logic [31:0] expq[$];
        logic [31:0] acc;
        int send, got_idx;
        bit prev;
        sel = 1'b0;
        do_reset();
        req_addr = $urandom; req_write = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
        send = 0; prev = 1'b0; acc = 32'h0;
        for (int t = 0; t < 70; t++) begin
            @(negedge clk);
            if (o_rsp_valid === 1'b1) begin
                n_cmp++;
                if (expq.size() == 0 || o_rsp_rdata !== expq[0]) begin
                    n_bad++; $display("FAIL b2b_rdata: got %h want %h", o_rsp_rdata, (expq.size() != 0) ? expq[0] : 32'h0);
                end
                if (expq.size() != 0) void'(expq.pop_front());
            end
            if (o_nib_out_valid === 1'b1 && !prev && o_nib_out === 4'h8) starts.push_back(t);
            if (o_nib_out_valid !== 1'b1 && prev) send = 8;
            if (send > 0) begin
                nib_in = 4'($urandom); nib_in_valid = 1'b1;
                acc[4*(8-send) +: 4] = nib_in;
                send--;
                if (send == 0) expq.push_back(acc);
            end else begin
                nib_in_valid = 1'b0;
            end
            prev = o_nib_out_valid;
        end
        req_valid = 1'b0; rsp_ready = 1'b0; nib_in_valid = 1'b0;
        n_cmp++;
        if (starts.size() < 3) begin
            n_bad++; $display("FAIL b2b_frames: got %0d want >=3", starts.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (starts[i] - starts[i-1] != 20) begin
                    n_bad++; $display("FAIL b2b_period: got %0d want 20", starts[i] - starts[i-1]);
                end
            end
        end
        got_idx = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_backpressure();
        test_addr3();
        test_back_to_back();
        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_nibble_bridge.md
# mem_nibble_bridge

Serialises the core's 32-bit data-memory request into a 4-bit nibble stream on the chip's bidirectional IO pins, and reassembles the nibble response into a 32-bit response. Sits directly downstream of the Snitch data port, after request/response channel merging. Drives `uio_out`/`uio_oe` and samples `uio_in`. One transaction is in flight at a time.

## Interface
- `ADDR_NIBBLES`, default 8: address nibbles sent per frame (1..8). Only the low `4*ADDR_NIBBLES` address bits are transmitted.
- `TIMEOUT`, default 255: maximum consecutive response-wait cycles without `nib_in_valid` before an error response. A value of 0 disables the timeout.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `req_strb`  in  4  byte-write enables. Only meaningful for writes.
- `req_write`  in  1  1 = write, 0 = read.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `rsp_rdata`  out  32  read data. 0 for writes and for errors.
- `rsp_error`  out  1  error flag, either from the device or from a timeout.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed.
- `nib_out`  out  4  outbound nibble.
- `nib_out_valid`  out  1  outbound nibble valid. Also used as the pad output enable.
- `nib_in`  in  4  inbound nibble.
- `nib_in_valid`  in  1  inbound nibble valid.

## Operation
- States: IDLE, HDR0, HDR1, ADDR, WDATA, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: capture addr, wdata, strb and write, then go to HDR0.
  - For reads, the captured strb is forced to 4'hF.
- HDR0: `nib_out`={1'b1, 2'b00, write}. Bit 3 is the start marker.
- HDR1: `nib_out`=strb.
- ADDR: `ADDR_NIBBLES` cycles, LSB nibble first, `nib_out`=addr[4k+3:4k] on the k-th cycle. Then:
  - write → WDATA;
  - read → WAIT.
- WDATA: 8 cycles, LSB nibble first. Then WAIT.
- `nib_out_valid`=1 exactly in HDR0, HDR1, ADDR and WDATA. Otherwise `nib_out`=0 and `nib_out_valid`=0.
- WAIT, read:
  - Each cycle with `nib_in_valid` shifts `nib_in` into rdata; the k-th accepted nibble lands in bits [4k+3:4k].
  - The 8th nibble completes the response: → RESP with `rsp_error`=0.
- WAIT, write:
  - The first `nib_in_valid` cycle completes the response: → RESP with `rsp_error`=`nib_in[0]` and rdata=0.
- Timeout:
  - The counter clears on entry to WAIT and on every `nib_in_valid` cycle. Otherwise it increments.
  - When it reaches `TIMEOUT` (nonzero): → RESP with `rsp_error`=1 and rdata=0. Any partial read data is discarded.
- RESP: `rsp_valid`=1 and outputs are held stable until `rsp_ready`. Then → IDLE.
- `nib_in_valid` outside WAIT is ignored.
- Reset: state IDLE, all shift registers and the counter cleared. Reset values:
  - `req_ready`=1;
  - `rsp_valid`=0, `rsp_error`=0, `rsp_rdata`=0;
  - `nib_out`=0, `nib_out_valid`=0.
- Reset asserted mid-frame or mid-wait aborts immediately. No response is produced, and `nib_out_valid` drops asynchronously.

## Timing
- All outputs are registered, or decoded from registered state only. There is no combinational path from `req_*`, `rsp_ready` or `nib_in*` to any output.
- Request accepted at edge 0 → first nibble (HDR0) on the wire in cycle 1.
- Outbound frame length: 2+`ADDR_NIBBLES` cycles for a read; 10+`ADDR_NIBBLES` cycles for a write. With defaults that is 10 and 18 cycles.
- Last outbound nibble in cycle N → WAIT from cycle N+1. `nib_in_valid` sampled in cycle N+1 counts.
- Final response nibble sampled at edge E → `rsp_valid`=1 from cycle E+1.
- `rsp_valid`&`rsp_ready` at edge F → `req_ready`=1 from cycle F+1. A new request is accepted no earlier than edge F+1.
- Minimum back-to-back read period with defaults: 1+10+8+1 = 20 cycles.

## Test plan
- Reset check:
  - Assert `rst` mid-WDATA → `nib_out_valid`=0 immediately.
  - After release, `req_ready`=1 and `rsp_valid`=0. A fresh read then completes normally.
- Read, defaults:
  - Stimulus: addr 32'h1234_5678; device returns nibbles 1,2,…,8 on consecutive WAIT cycles.
  - Wire sees 8,F,8,7,6,5,4,3,2,1.
  - `rsp_rdata`=32'h8765_4321, `rsp_error`=0.
- Write:
  - Stimulus: addr 32'h0000_0010, wdata 32'hCAFE_BABE, strb 4'b0011; device acks with 4'h0.
  - Wire sees 9,3,0,1,0,0,0,0,0,0,E,B,A,B,E,F,A,C.
  - `rsp_error`=0, `rsp_rdata`=0.
  - A repeat with ack 4'h1 gives `rsp_error`=1.
- Timeout, `TIMEOUT`=4:
  - Read; device sends 3 nibbles, then stays silent.
  - `rsp_valid` rises on the 5th cycle after the last valid nibble, with `rsp_error`=1 and rdata=0.
- Response backpressure:
  - Hold `rsp_ready`=0 for 10 cycles → `rsp_valid` and `rsp_rdata` stay stable and `req_ready`=0.
  - `req_valid` held high meanwhile is not accepted until the cycle after the `rsp_ready` handshake.
- `ADDR_NIBBLES`=3:
  - Read of addr 32'hFFFF_FABC → frame 8,F,C,B,A.
  - WAIT is entered in cycle 6.
